dmi_txn_tracker: RTL and testbench

//  Sits directly downstream of the DMI request register stage. Accepts one dm::dmi_req_t
//  at a time, forwards READ/WRITE to the DM core, and waits for the core's dm::dmi_resp_t.

---
 rtl/dmi_txn_tracker_if.sv | 30 +++
 rtl/dmi_txn_tracker.sv | 141 ++++++++++++++
 tb/tb_dmi_txn_tracker.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_txn_tracker_if.sv
// Handshake bundle between the DMI request stage, the tracker, the DM core and the DTM.
// slave is the tracker's view; master is the view of whatever surrounds it.
interface dmi_txn_tracker_if;
  logic [40:0] dmi_req;
  logic        dmi_req_valid;
  logic        dmi_req_ready;
  logic [40:0] dm_req;
  logic        dm_req_valid;
  logic        dm_req_ready;
  logic [33:0] dm_resp;
  logic        dm_resp_valid;
  logic        dm_resp_ready;
  logic [33:0] dmi_resp;
  logic        dmi_resp_valid;
  logic        dmi_resp_ready;
  logic        busy;
  logic        timeout;

  modport slave (
    input  dmi_req, dmi_req_valid, dm_req_ready, dm_resp, dm_resp_valid, dmi_resp_ready,
    output dmi_req_ready, dm_req, dm_req_valid, dm_resp_ready, dmi_resp, dmi_resp_valid,
           busy, timeout
  );

  modport master (
    output dmi_req, dmi_req_valid, dm_req_ready, dm_resp, dm_resp_valid, dmi_resp_ready,
    input  dmi_req_ready, dm_req, dm_req_valid, dm_resp_ready, dmi_resp, dmi_resp_valid,
           busy, timeout
  );
endinterface

// File: rtl/dmi_txn_tracker.sv
// Single-outstanding DMI transaction tracker: forwards READ/WRITE to the DM core and
// always returns a registered response upstream, synthesising one for NOP or a stalled core.
//   state | meaning
//   IDLE  | ready for a new DMI request
//   ISSUE | request offered to the DM core
//   WAIT  | waiting for the core response, timeout counter running
//   RESP  | response offered to the DTM
//   DRAIN | after a timeout, swallowing a late core response (bounded)
module dmi_txn_tracker #(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  dmi_txn_tracker_if.slave   bus
);
  localparam int unsigned     CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [1:0]      OpNop   = 2'b00;
  localparam logic [1:0]      OpRead  = 2'b01;
  localparam logic [1:0]      OpWrite = 2'b10;
  localparam logic [1:0]      RespOk  = 2'b00;
  localparam logic [1:0]      RespErr = 2'b10;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            drop_q, drop_d;
  logic [40:0]     dm_req_q, dm_req_d;
  logic [33:0]     dmi_resp_q, dmi_resp_d;
  logic            timeout_q, timeout_d;
  logic            dmi_req_ready_q, dmi_req_ready_d;
  logic            dm_req_valid_q, dm_req_valid_d;
  logic            dm_resp_ready_q, dm_resp_ready_d;
  logic            dmi_resp_valid_q, dmi_resp_valid_d;
  logic            busy_q, busy_d;
  logic [1:0]      req_op;

  assign req_op = bus.dmi_req[33:32];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    dm_req_d   = dm_req_q;
    dmi_resp_d = dmi_resp_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.dmi_req_valid) begin
          if (req_op == OpRead || req_op == OpWrite) begin
            dm_req_d = bus.dmi_req;
            state_d  = ISSUE;
          end else begin
            dmi_resp_d = {32'h0, (req_op == OpNop) ? RespOk : RespErr};
            state_d    = RESP;
          end
        end
      end
      ISSUE: begin
        if (bus.dm_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (bus.dm_resp_valid) begin
          dmi_resp_d = bus.dm_resp;
          cnt_d      = '0;
          state_d    = RESP;
        end else if (cnt_q == CntLast) begin
          dmi_resp_d = {32'h0, RespErr};
          timeout_d  = 1'b1;
          drop_d     = 1'b1;
          cnt_d      = '0;
          state_d    = RESP;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RESP: begin
        if (bus.dmi_resp_ready) state_d = drop_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (bus.dm_resp_valid || cnt_q == CntLast) begin
          drop_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    dmi_req_ready_d  = (state_d == IDLE);
    dm_req_valid_d   = (state_d == ISSUE);
    dm_resp_ready_d  = (state_d == WAIT) || (state_d == DRAIN);
    dmi_resp_valid_d = (state_d == RESP);
    busy_d           = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      drop_q           <= 1'b0;
      dm_req_q         <= '0;
      dmi_resp_q       <= '0;
      timeout_q        <= 1'b0;
      dmi_req_ready_q  <= 1'b1;
      dm_req_valid_q   <= 1'b0;
      dm_resp_ready_q  <= 1'b0;
      dmi_resp_valid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      drop_q           <= drop_d;
      dm_req_q         <= dm_req_d;
      dmi_resp_q       <= dmi_resp_d;
      timeout_q        <= timeout_d;
      dmi_req_ready_q  <= dmi_req_ready_d;
      dm_req_valid_q   <= dm_req_valid_d;
      dm_resp_ready_q  <= dm_resp_ready_d;
      dmi_resp_valid_q <= dmi_resp_valid_d;
      busy_q           <= busy_d;
    end
  end

  assign bus.dmi_req_ready  = dmi_req_ready_q;
  assign bus.dm_req         = dm_req_q;
  assign bus.dm_req_valid   = dm_req_valid_q;
  assign bus.dm_resp_ready  = dm_resp_ready_q;
  assign bus.dmi_resp       = dmi_resp_q;
  assign bus.dmi_resp_valid = dmi_resp_valid_q;
  assign bus.busy           = busy_q;
  assign bus.timeout        = timeout_q;
endmodule

// File: tb/tb_dmi_txn_tracker.sv
// Bench for dmi_txn_tracker: scoreboard of expected DTM responses plus per-scenario
// cycle-accurate checks, with a short timeout so timeout and drain paths are reachable.
module tb_dmi_txn_tracker;
  localparam int unsigned T = 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  dmi_txn_tracker_if bus();

  dmi_txn_tracker #(.TimeoutCycles(T)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_exp;

  // Every DTM-side response handshake must match the oldest expected response.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && bus.dmi_resp_valid === 1'b1 && bus.dmi_resp_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp: got %h, required no response", bus.dmi_resp);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.dmi_resp !== mon_exp) begin
          fails++;
          $display("FAIL resp_payload: got %h, required %h", bus.dmi_resp, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives a request in the current cycle, checks it is accepted, returns one cycle later.
  task automatic issue(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
    bus.dmi_req       = {addr, op, data};
    bus.dmi_req_valid = 1'b1;
    @(negedge clk_i);
    tests++;
    if (bus.dmi_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL req_accept: ready=%b, required 1", bus.dmi_req_ready);
    end
    tick();
    bus.dmi_req_valid = 1'b0;
  endtask

  task automatic core_resp(input logic [33:0] r);
    bus.dm_resp       = r;
    bus.dm_resp_valid = 1'b1;
    tick();
    bus.dm_resp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_i);
    while (bus.busy !== 1'b0 && n < 40) begin
      tick();
      @(negedge clk_i);
      n++;
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", bus.busy, n);
    end
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    tests++;
    if ({bus.dmi_req_ready, bus.dm_req_valid, bus.dm_resp_ready, bus.dmi_resp_valid,
         bus.busy, bus.timeout} !== 6'b100000) begin
      fails++;
      $display("FAIL %s_flags: rdy/reqv/rspr/rspv/busy/to=%b, required 100000", tag,
               {bus.dmi_req_ready, bus.dm_req_valid, bus.dm_resp_ready, bus.dmi_resp_valid,
                bus.busy, bus.timeout});
    end
    tests++;
    if (bus.dm_req !== 41'h0) begin
      fails++;
      $display("FAIL %s_dm_req: got %h, required 0", tag, bus.dm_req);
    end
    tests++;
    if (bus.dmi_resp !== 34'h0) begin
      fails++;
      $display("FAIL %s_dmi_resp: got %h, required 0", tag, bus.dmi_resp);
    end
  endtask

  task automatic read_txn(input logic [6:0] addr, input logic [31:0] data);
    exp_q.push_back({data, 2'b00});
    issue(2'b01, addr, 32'h0);
    tick();
    core_resp({data, 2'b00});
    wait_idle();
  endtask

  task automatic test_reset();
    rst_ni             = 1'b0;
    bus.dmi_req        = '0;
    bus.dmi_req_valid  = 1'b0;
    bus.dm_req_ready   = 1'b1;
    bus.dm_resp        = '0;
    bus.dm_resp_valid  = 1'b0;
    bus.dmi_resp_ready = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_values("reset");
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_read();
    exp_q.push_back({32'hDEADBEEF, 2'b00});
    issue(2'b01, 7'h11, 32'h0);
    @(negedge clk_i);
    tests++;
    if (bus.dm_req_valid !== 1'b1 || bus.dm_req !== {7'h11, 2'b01, 32'h0}) begin
      fails++;
      $display("FAIL read_issue: valid=%b req=%h, required 1 %h", bus.dm_req_valid, bus.dm_req,
               {7'h11, 2'b01, 32'h0});
    end
    tick();
    bus.dm_resp       = {32'hDEADBEEF, 2'b00};
    bus.dm_resp_valid = 1'b1;
    @(negedge clk_i);
    tests++;
    if (bus.dm_resp_ready !== 1'b1) begin
      fails++;
      $display("FAIL read_wait_ready: got %b, required 1", bus.dm_resp_ready);
    end
    tick();
    bus.dm_resp_valid = 1'b0;
    @(negedge clk_i);
    tests++;
    if (bus.dmi_resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL read_resp_n3: valid=%b, required 1", bus.dmi_resp_valid);
    end
    tick();
    @(negedge clk_i);
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL read_busy_n4: busy=%b, required 0", bus.busy);
    end
    tick();
  endtask

  task automatic test_nop();
    exp_q.push_back(34'h0);
    issue(2'b00, 7'h3A, 32'hFFFF_FFFF);
    @(negedge clk_i);
    tests++;
    if (bus.dmi_resp_valid !== 1'b1 || bus.dm_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL nop_resp_n1: rspv=%b reqv=%b, required 1 0", bus.dmi_resp_valid,
               bus.dm_req_valid);
    end
    tick();
    @(negedge clk_i);
    tests++;
    if (bus.dm_req_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL nop_after: reqv=%b busy=%b, required 0 0", bus.dm_req_valid, bus.busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(34'h0);
    issue(2'b00, 7'h01, 32'h0);
    @(negedge clk_i);
    tests++;
    if (bus.dmi_req_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready_in_resp: got %b, required 0", bus.dmi_req_ready);
    end
    tick();
    // reserved op: error response, still no core request
    exp_q.push_back({32'h0, 2'b10});
    issue(2'b11, 7'h02, 32'h1234);
    wait_idle();
  endtask

  task automatic test_timeout_drain();
    int  k = 1;
    bit  found = 1'b0;
    exp_q.push_back({32'h0, 2'b10});
    issue(2'b10, 7'h05, 32'h55);
    while (k <= 20) begin
      @(negedge clk_i);
      if (bus.timeout === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
      k++;
    end
    tests++;
    if (!found || k != 10) begin
      fails++;
      $display("FAIL timeout_cycle: pulse at cycle %0d (found=%0b), required 10", k, found);
    end
    tests++;
    if (bus.dmi_resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL timeout_resp_valid: got %b, required 1", bus.dmi_resp_valid);
    end
    tick();
    @(negedge clk_i);
    tests++;
    if ({bus.timeout, bus.dmi_req_ready, bus.dm_resp_ready, bus.busy} !== 4'b0011) begin
      fails++;
      $display("FAIL drain_entry: to/rdy/rspr/busy=%b, required 0011",
               {bus.timeout, bus.dmi_req_ready, bus.dm_resp_ready, bus.busy});
    end
    tick();
    tick();
    tick();
    core_resp({32'hCAFEF00D, 2'b00});
    @(negedge clk_i);
    tests++;
    if (bus.dmi_req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL drain_discard: rdy=%b busy=%b, required 1 0", bus.dmi_req_ready, bus.busy);
    end
    tick();
    read_txn(7'h22, 32'h12345678);
  endtask

  task automatic test_drain_silent();
    exp_q.push_back({32'h0, 2'b10});
    issue(2'b10, 7'h06, 32'h66);
    repeat (10) tick();
    repeat (7) tick();
    @(negedge clk_i);
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL drain_last_cycle: busy=%b, required 1", bus.busy);
    end
    tick();
    @(negedge clk_i);
    tests++;
    if (bus.busy !== 1'b0 || bus.dmi_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL drain_expire: busy=%b rdy=%b, required 0 1", bus.busy, bus.dmi_req_ready);
    end
    tick();
  endtask

  task automatic test_resp_beats_timeout();
    issue(2'b10, 7'h07, 32'h77);
    repeat (8) tick();
    exp_q.push_back({32'hA5A5A5A5, 2'b01});
    core_resp({32'hA5A5A5A5, 2'b01});
    @(negedge clk_i);
    tests++;
    if (bus.timeout !== 1'b0 || bus.dmi_resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL race_resp: to=%b rspv=%b, required 0 1", bus.timeout, bus.dmi_resp_valid);
    end
    tick();
    @(negedge clk_i);
    tests++;
    if (bus.dmi_req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL race_no_drain: rdy=%b busy=%b, required 1 0", bus.dmi_req_ready, bus.busy);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.dmi_resp_ready = 1'b0;
    exp_q.push_back({32'h0BADF00D, 2'b11});
    issue(2'b01, 7'h33, 32'h0);
    tick();
    core_resp({32'h0BADF00D, 2'b11});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      tests++;
      if ({bus.dmi_resp_valid, bus.dmi_req_ready, bus.dm_resp_ready} !== 3'b100 ||
          bus.dmi_resp !== {32'h0BADF00D, 2'b11}) begin
        fails++;
        $display("FAIL hold_%0d: v/rdy/rspr=%b data=%h, required 100 %h", i,
                 {bus.dmi_resp_valid, bus.dmi_req_ready, bus.dm_resp_ready}, bus.dmi_resp,
                 {32'h0BADF00D, 2'b11});
      end
      tick();
    end
    bus.dmi_resp_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    exp_q.push_back({32'h99999999, 2'b00});
    issue(2'b01, 7'h44, 32'h0);
    tick();
    tick();
    rst_ni = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check_reset_values("midreset");
    tick();
    rst_ni = 1'b1;
    core_resp({32'h77777777, 2'b00});
    begin
      bit bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk_i);
        if (bus.dmi_resp_valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        tick();
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL midreset_quiet: activity seen after release, required none");
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_nop();
    test_back_to_back();
    test_timeout_drain();
    test_drain_silent();
    test_resp_beats_timeout();
    test_backpressure();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
